scv_fracclk: RTL and testbench

//  Multi-channel fractional clock-enable generator; parametrised successor to the fixed three-ratio SCV clock generator.

---
 rtl/scv_fracclk_if.sv | 15 +
 rtl/scv_fracclk.sv | 123 ++++++++++++
 tb/tb_scv_fracclk.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/scv_fracclk_if.sv
// Configuration bus for scv_fracclk. The master writes ratios; the slave reports
// which channels still hold an unapplied ratio.
interface scv_fracclk_if #(
   parameter int unsigned NCH = 3,
   parameter int unsigned W   = 10
);
   logic           CFG_WE;
   logic [2:0]     CFG_CH;
   logic [W-1:0]   CFG_MUL;
   logic [W-1:0]   CFG_DIV;
   logic [NCH-1:0] CFG_PEND;

   modport master (output CFG_WE, CFG_CH, CFG_MUL, CFG_DIV, input CFG_PEND);
   modport slave  (input CFG_WE, CFG_CH, CFG_MUL, CFG_DIV, output CFG_PEND);
endinterface

// File: rtl/scv_fracclk.sv
// Multi-channel fractional clock-enable generator. Each channel runs a Bresenham
// accumulator that emits CE at an average rate of CLK*MUL/DIV. Channel 0 also
// drives a rotating one-hot phase strobe set used for the CPU CP1/CP2 edges.
module scv_fracclk #(
   parameter int unsigned      NCH     = 3,
   parameter int unsigned      W       = 10,
   parameter int unsigned      NPHASE  = 4,
   parameter logic [NCH*W-1:0] DEF_MUL = {10'd22, 10'd1, 10'd88},
   parameter logic [NCH*W-1:0] DEF_DIV = {10'd105, 10'd7, 10'd315},
   localparam int unsigned     PW      = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
   input  logic              CLK,
   input  logic              RESB,
   input  logic [NCH-1:0]    EN,
   scv_fracclk_if.slave      cfg,
   output logic [NCH-1:0]    CE,
   output logic [NPHASE-1:0] PH_CE,
   output logic [PW-1:0]     PH_IDX
);

   logic [W:0]        acc_q  [NCH];
   logic [W:0]        acc_d  [NCH];
   logic [W:0]        sum    [NCH];
   logic [W-1:0]      mul_q  [NCH];
   logic [W-1:0]      div_q  [NCH];
   logic [W-1:0]      pmul_q [NCH];
   logic [W-1:0]      pdiv_q [NCH];
   logic [NCH-1:0]    pend_q;
   logic [NCH-1:0]    ce_q;
   logic [NCH-1:0]    tick;
   logic [NCH-1:0]    stall;
   logic [NCH-1:0]    apply;
   logic [NCH-1:0]    wr_sel;
   logic [PW-1:0]     phase_q;
   logic [PW-1:0]     phase_next;
   logic [NPHASE-1:0] ph_ce_q;
   logic [NPHASE-1:0] ph_onehot;

   // Per-channel accumulator step, tick decision and pending-ratio apply condition.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         sum[i]    = acc_q[i] + {1'b0, mul_q[i]};
         stall[i]  = (mul_q[i] == '0) || (div_q[i] == '0);
         tick[i]   = 1'b0;
         acc_d[i]  = acc_q[i];
         if (EN[i] && !stall[i]) begin
            if (mul_q[i] >= div_q[i]) begin
               // Ratio of one or more: tick every cycle, nothing to carry.
               tick[i]  = 1'b1;
               acc_d[i] = '0;
            end else if (sum[i] >= {1'b0, div_q[i]}) begin
               tick[i]  = 1'b1;
               acc_d[i] = sum[i] - {1'b0, div_q[i]};
            end else begin
               acc_d[i] = sum[i];
            end
         end
         // A new ratio lands on a tick boundary, or at once if the channel is idle.
         apply[i]  = pend_q[i] && (tick[i] || !EN[i] || stall[i]);
         if (apply[i]) begin
            acc_d[i] = '0;
         end
         wr_sel[i] = cfg.CFG_WE && (cfg.CFG_CH == 3'(i));
      end
   end

   // Channel state: accumulators, active and pending ratios, registered CE.
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         for (int i = 0; i < NCH; i++) begin
            acc_q[i]  <= '0;
            mul_q[i]  <= DEF_MUL[i*W +: W];
            div_q[i]  <= DEF_DIV[i*W +: W];
            pmul_q[i] <= '0;
            pdiv_q[i] <= '0;
         end
         pend_q <= '0;
         ce_q   <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            acc_q[i] <= acc_d[i];
            // Apply takes the pending value from before any same-cycle write.
            if (apply[i]) begin
               mul_q[i] <= pmul_q[i];
               div_q[i] <= pdiv_q[i];
            end
            if (wr_sel[i]) begin
               pmul_q[i] <= cfg.CFG_MUL;
               pdiv_q[i] <= cfg.CFG_DIV;
            end
            pend_q[i] <= wr_sel[i] || (pend_q[i] && !apply[i]);
         end
         ce_q <= tick;
      end
   end

   // Decode the current phase and its successor for channel 0.
   always_comb begin
      ph_onehot          = '0;
      ph_onehot[phase_q] = 1'b1;
      phase_next         = (phase_q == PW'(NPHASE - 1)) ? '0 : phase_q + PW'(1);
   end

   // Phase strobes advance only on channel-0 ticks; a ratio change leaves phase alone.
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         phase_q <= '0;
         ph_ce_q <= '0;
      end else begin
         ph_ce_q <= '0;
         if (tick[0]) begin
            ph_ce_q <= ph_onehot;
            phase_q <= phase_next;
         end
      end
   end

   assign CE           = ce_q;
   assign PH_CE        = ph_ce_q;
   assign PH_IDX       = phase_q;
   assign cfg.CFG_PEND = pend_q;

endmodule

// File: tb/tb_scv_fracclk.sv
// Directed bench for scv_fracclk: default ratios, phase strobes, runtime ratio
// writes, enable gaps and asynchronous reset with a pending write.
module tb_scv_fracclk;

   localparam int unsigned NCH    = 3;
   localparam int unsigned W      = 10;
   localparam int unsigned NPHASE = 4;

   logic       CLK  = 1'b0;
   logic       RESB = 1'b0;
   logic [2:0] EN;
   logic [2:0] CE;
   logic [3:0] PH_CE;
   logic [1:0] PH_IDX;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   scv_fracclk_if #(.NCH(NCH), .W(W)) cfg ();

   scv_fracclk #(
      .NCH    (NCH),
      .W      (W),
      .NPHASE (NPHASE)
   ) dut (
      .CLK    (CLK),
      .RESB   (RESB),
      .EN     (EN),
      .cfg    (cfg),
      .CE     (CE),
      .PH_CE  (PH_CE),
      .PH_IDX (PH_IDX)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic write_cfg(input logic [2:0] ch, input logic [W-1:0] mul,
                            input logic [W-1:0] dv);
      cfg.CFG_WE  = 1'b1;
      cfg.CFG_CH  = ch;
      cfg.CFG_MUL = mul;
      cfg.CFG_DIV = dv;
      step();
      cfg.CFG_WE  = 1'b0;
   endtask

   task automatic do_reset();
      RESB = 1'b0;
      EN   = 3'b111;
      step();
      step();
      RESB = 1'b1;
   endtask

   initial begin
      int unsigned first0, first1, first2, cnt0, cnt1, cnt2, ph_k, ph_err, per1_err;
      int unsigned m2, s2;
      logic        e2;

      EN          = 3'b111;
      cfg.CFG_WE  = 1'b0;
      cfg.CFG_CH  = '0;
      cfg.CFG_MUL = '0;
      cfg.CFG_DIV = '0;
      #3;
      check("rst_ce", CE, 0);
      check("rst_ph_ce", PH_CE, 0);
      check("rst_ph_idx", PH_IDX, 0);
      check("rst_pend", cfg.CFG_PEND, 0);
      step();
      step();
      RESB = 1'b1;

      // Default ratios over one full common period.
      first0 = 0; first1 = 0; first2 = 0;
      cnt0 = 0; cnt1 = 0; cnt2 = 0;
      ph_k = 0; ph_err = 0; per1_err = 0;
      for (int c = 1; c <= 3150; c++) begin
         step();
         if (CE[0]) begin
            cnt0++;
            if (first0 == 0) first0 = c;
            if (PH_CE !== (4'b0001 << (ph_k % 4))) ph_err++;
            ph_k++;
         end else if (PH_CE !== 4'b0000) begin
            ph_err++;
         end
         if (CE[1]) begin
            cnt1++;
            if (first1 == 0) first1 = c;
         end
         if (CE[2]) begin
            cnt2++;
            if (first2 == 0) first2 = c;
         end
         if (CE[1] !== ((c % 7) == 0)) per1_err++;
         if (c == 4) check("ph_idx_after_first", PH_IDX, 1);
      end
      check("first_ce0", first0, 4);
      check("first_ce1", first1, 7);
      check("first_ce2", first2, 5);
      check("cnt_ce0", cnt0, 880);
      check("cnt_ce1", cnt1, 450);
      check("cnt_ce2", cnt2, 660);
      check("ph_seq_err", ph_err, 0);
      check("ce1_period7_err", per1_err, 0);
      check("ph_idx_end", PH_IDX, 0);

      // Ratio 1/3 on ch1 written mid-period; applies on the next ch1 tick.
      step(); step(); step();
      write_cfg(3'd1, 10'd1, 10'd3);
      check("pend_set", cfg.CFG_PEND, 3'b010);
      for (int k = 1; k <= 12; k++) begin
         step();
         check("ce1_ratio13", CE[1], (k == 3) || (k > 3 && ((k - 3) % 3) == 0));
         check("pend1_13", cfg.CFG_PEND[1], k < 3);
      end

      // MUL == DIV: CE every cycle after apply.
      write_cfg(3'd1, 10'd5, 10'd5);
      check("pend_55", cfg.CFG_PEND[1], 1);
      for (int i = 0; i < 10 && cfg.CFG_PEND[1]; i++) step();
      check("pend_clear_55", cfg.CFG_PEND[1], 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("ce1_every", CE[1], 1);
      end

      // DIV == 0: the apply tick still emits CE, then the channel stalls.
      write_cfg(3'd1, 10'd5, 10'd0);
      check("pend_div0", cfg.CFG_PEND[1], 1);
      step();
      check("apply_tick_ce", CE[1], 1);
      check("pend_clear_div0", cfg.CFG_PEND[1], 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("ce1_stalled", CE[1], 0);
      end

      // Stalled channel takes a new ratio the cycle after the write.
      write_cfg(3'd1, 10'd1, 10'd7);
      check("pend_stall_wr", cfg.CFG_PEND[1], 1);
      step();
      check("pend_stall_apply", cfg.CFG_PEND[1], 0);
      for (int k = 1; k <= 7; k++) begin
         step();
         check("ce1_after_stall", CE[1], k == 7);
      end

      // Out-of-range channel select is ignored.
      write_cfg(3'd7, 10'd0, 10'd0);
      check("pend_ch7", cfg.CFG_PEND, 0);
      for (int k = 9; k <= 14; k++) begin
         step();
         check("ce1_ch7_nochg", CE[1], k == 14);
      end

      // Write coinciding with an apply: old pending applied, new one stays pending.
      EN[1] = 1'b0;
      write_cfg(3'd1, 10'd1, 10'd2);
      check("pend_en0_wr", cfg.CFG_PEND[1], 1);
      write_cfg(3'd1, 10'd1, 10'd3);
      EN[1] = 1'b1;
      check("pend_wr_apply", cfg.CFG_PEND[1], 1);
      for (int k = 2; k <= 6; k++) begin
         step();
         check("ce1_wr_apply", CE[1], (k == 3) || (k == 6));
         check("pend1_wr_apply", cfg.CFG_PEND[1], k < 3);
      end

      // EN[2] gap: accumulator frozen, no catch-up on resume.
      do_reset();
      m2 = 0;
      for (int c = 1; c <= 200; c++) begin
         EN[2] = !(c >= 60 && c < 110);
         if (EN[2]) begin
            s2 = m2 + 22;
            if (s2 >= 105) begin
               m2 = s2 - 105;
               e2 = 1'b1;
            end else begin
               m2 = s2;
               e2 = 1'b0;
            end
         end else begin
            e2 = 1'b0;
         end
         step();
         check("ce2_en_gap", CE[2], e2);
      end

      // Asynchronous reset with a pending write drops everything.
      write_cfg(3'd0, 10'd1, 10'd2);
      check("pend_before_rst", cfg.CFG_PEND, 3'b001);
      #2;
      RESB = 1'b0;
      #1;
      check("async_rst_ce", CE, 0);
      check("async_rst_ph_ce", PH_CE, 0);
      check("async_rst_ph_idx", PH_IDX, 0);
      check("async_rst_pend", cfg.CFG_PEND, 0);
      step();
      step();
      RESB = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         step();
         check("post_rst_ce0", CE[0], c == 4);
         check("post_rst_ce1", CE[1], c == 7);
         check("post_rst_ph_ce", PH_CE, (c == 4) ? 4'b0001 : 4'b0000);
      end
      check("post_rst_pend", cfg.CFG_PEND, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
